// File: rtl/nios_security_led_driver.sv
// nios_security_led_driver: double-buffered PIO control word -> PWM/blink LED drive, applied only at PWM period boundaries
module nios_security_led_driver #(
  parameter int NUM_LEDS   = 8,
  parameter int CLK_DIV    = 195,
  parameter int BLINK_HALF = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         ctrl_word,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [31:0]         cfg_active,
  output logic                period_start
);
  logic [15:0] presc_q, presc_d;
  logic [7:0] pwm_q, pwm_d;
  logic [10:0] blink_q, blink_d;
  logic phase_q, phase_d;
  logic [31:0] cfg_q, cfg_d;
  logic ps_q;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic tick, bnd, rate_chg, wrap, pwm_on;
  logic [10:0] half;
  always_comb begin
    tick     = presc_q == 16'(CLK_DIV - 1);
    bnd      = tick & (pwm_q == 8'hFF);
    half     = 11'(BLINK_HALF) << cfg_q[25:24];
    rate_chg = ctrl_word[25:24] != cfg_q[25:24];
    wrap     = blink_q == half - 11'd1;
    presc_d  = tick ? 16'd0 : presc_q + 16'd1;
    pwm_d    = tick ? pwm_q + 8'd1 : pwm_q;
    cfg_d    = bnd ? ctrl_word : cfg_q;
    // a rate change restarts the half-cycle count without flipping the phase
    blink_d  = !bnd ? blink_q : (rate_chg | wrap) ? 11'd0 : blink_q + 11'd1;
    phase_d  = phase_q ^ (bnd & ~rate_chg & wrap);
    pwm_on   = (cfg_q[23:16] == 8'hFF) | (pwm_q < cfg_q[23:16]);
    led_d    = {NUM_LEDS{cfg_q[31] & pwm_on}} & cfg_q[NUM_LEDS-1:0]
             & (~cfg_q[8 +: NUM_LEDS] | {NUM_LEDS{~phase_q}});
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      pwm_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      cfg_q   <= '0;
      ps_q    <= 1'b0;
      led_q   <= '0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      cfg_q   <= cfg_d;
      ps_q    <= bnd;
      led_q   <= led_d;
    end
  end
  assign led_out      = led_q;
  assign cfg_active   = cfg_q;
  assign period_start = ps_q;
endmodule
